adc_frame_sequencer: RTL and testbench
======================================

# adc_frame_sequencer

Sequences the modular ADC's Avalon-ST response stream into stereo audio frames for the audio buffer. It selects two configured ADC channels as left and right, and converts each 12-bit unsigned sample to 16-bit signed. Once both halves are captured, it presents one frame on a valid/ready handshake. It sits between the ADC response port and the audio buffer write side, and counts dropped and out-of-order samples.

## Interface
- LEFT_CH, 1: ADC channel number mapped to the left sample.
- RIGHT_CH, 2: ADC channel number mapped to the right sample; must differ from LEFT_CH.
- clk_clk  input  1  ADC/system clock; all logic is on its rising edge.
- reset_reset  input  1  asynchronous, active-high reset.
- enable  input  1  run control; 0 forces IDLE.
- adc_response_valid  input  1  response beat valid (the ADC has no backpressure).
- adc_response_startofpacket  input  1  ignored.
- adc_response_endofpacket  input  1  ignored.
- adc_response_empty  input  1  ignored.
- adc_response_channel  input  5  channel of the beat.
- adc_response_data  input  12  unsigned sample.
- frame_valid  output  1  frame available.
- frame_ready  input  1  buffer accepts the frame.
- frame_left  output  16  signed left sample.
- frame_right  output  16  signed right sample.
- overrun_count  output  8  saturating count of samples dropped while a frame was pending.
- sync_err_count  output  8  saturating count of left samples that arrived while waiting for right.

## Operation
- Beat: adc_response_valid=1. A beat on any other channel is ignored in every state.
- Conversion: out = {~data[11], data[10:0], 4'b0000}. This gives 0x000→0x8000, 0x800→0x0000, 0xFFF→0x7FF0.
- FSM states: IDLE, WAIT_L, WAIT_R, PRESENT.
- IDLE → WAIT_L when enable=1.
- WAIT_L: a left beat stores frame_left and moves to WAIT_R. A right beat is discarded and not counted.
- WAIT_R: a right beat stores frame_right and moves to PRESENT. A left beat overwrites frame_left, stays in WAIT_R, and increments sync_err_count.
- PRESENT: frame_valid=1. Leave when frame_valid && frame_ready, going to WAIT_L. Any left or right beat in PRESENT is dropped and increments overrun_count, including a beat in the handshake cycle.
- enable=0 in any state moves to IDLE on the next edge. A partial frame or an untaken frame is discarded. The counters hold their values.
- Counters saturate at 0xFF and clear only on reset.
- If a beat and the handshake occur in the same cycle, the handshake wins and the beat counts as an overrun.

## Timing
- Reset values: frame_valid=0, frame_left=0, frame_right=0, both counters=0, state=IDLE.
- frame_left and frame_right are registered. frame_left updates the cycle after its left beat.
- frame_valid rises the cycle after the right beat is captured: 1 cycle latency from the right beat.
- While frame_valid=1, frame_left and frame_right are stable until the handshake.
- After the handshake, frame_valid=0 on the next cycle. The earliest next frame needs two more beats.
- frame_valid never depends combinationally on frame_ready.
- An asserted reset mid-frame clears everything asynchronously. Operation resumes via IDLE.

## Configuration
- ADC_SEQ_STATS_EN defined: overrun_count and sync_err_count are implemented as described.
- ADC_SEQ_STATS_EN undefined: both counters are constant 0 and their registers are removed. FSM behaviour is identical, including dropped and overwritten samples.

## Structure
- Package adc_seq_pkg holds:
  - the state enum (IDLE, WAIT_L, WAIT_R, PRESENT);
  - ADC_DATA_W=12, AUDIO_W=16, CNT_W=8.
- Natural sub-module: adc_sample_convert, a combinational 12-bit unsigned to 16-bit signed conversion. It is instantiated once and shared by the left and right captures.
- Top level holds the FSM, sample registers and saturating counters.

## Test plan
- Stereo frame: enable=1, beat ch1 data=0xFFF, then ch2 data=0x000, frame_ready=1 → frame_valid one cycle after the ch2 beat, left=0x7FF0, right=0x8000, then frame_valid=0 on the next cycle.
- Backpressure: frame_ready=0, three further ch1/ch2 beats → frame held unchanged, overrun_count=3. Raise frame_ready → one handshake, then WAIT_L.
- Desync: in WAIT_R, beat ch1 0x800 then ch2 0x800 → sync_err_count=1, frame left=0x0000, right=0x0000.
- Filtering: beats on ch0, ch3 and ch31 interleaved with a valid pair → exactly one frame, counters unchanged. Beats with adc_response_valid=0 have no effect.
- Disable/reset mid-frame: drop enable in WAIT_R → IDLE, and no frame appears when the pair later completes. Assert reset_reset during PRESENT → all outputs 0 immediately.
- Saturation: 300 beats while stalled in PRESENT → overrun_count=0xFF. With ADC_SEQ_STATS_EN undefined, the same stimulus gives 0.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared widths and FSM state encoding for the ADC frame sequencer.
package adc_seq_pkg;

  localparam int unsigned ADC_DATA_W = 12;
  localparam int unsigned AUDIO_W    = 16;
  localparam int unsigned CNT_W      = 8;

  // Sequencer state enumeration, kept as plain constants for legacy tools.
  typedef logic [1:0] adc_seq_state_t;

  localparam adc_seq_state_t IDLE    = 2'd0;
  localparam adc_seq_state_t WAIT_L  = 2'd1;
  localparam adc_seq_state_t WAIT_R  = 2'd2;
  localparam adc_seq_state_t PRESENT = 2'd3;

endpackage

// File: rtl/adc_sample_convert.sv
// Combinational offset-binary to two's-complement conversion, left-justified into the audio word.
module adc_sample_convert
  import adc_seq_pkg::*;
(
  input  logic [ADC_DATA_W-1:0] data,
  output logic [AUDIO_W-1:0]    sample
);

  // Flipping the MSB recentres mid-scale (0x800) onto zero.
  assign sample = {~data[ADC_DATA_W-1], data[ADC_DATA_W-2:0], {(AUDIO_W - ADC_DATA_W){1'b0}}};

endmodule

// File: rtl/adc_frame_sequencer.sv
// Assembles left/right ADC samples into stereo frames on a valid/ready handshake.
// Optional statistics counters are built when ADC_SEQ_STATS_EN is defined.
module adc_frame_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned LEFT_CH  = 1,
  parameter int unsigned RIGHT_CH = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  enable,
  input  logic                  adc_response_valid,
  input  logic                  adc_response_startofpacket,
  input  logic                  adc_response_endofpacket,
  input  logic                  adc_response_empty,
  input  logic [4:0]            adc_response_channel,
  input  logic [ADC_DATA_W-1:0] adc_response_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [AUDIO_W-1:0]    frame_left,
  output logic [AUDIO_W-1:0]    frame_right,
  output logic [CNT_W-1:0]      overrun_count,
  output logic [CNT_W-1:0]      sync_err_count
);

  localparam logic [4:0] LeftChan  = 5'(LEFT_CH);
  localparam logic [4:0] RightChan = 5'(RIGHT_CH);

  adc_seq_state_t     state_q, state_d;
  logic               left_beat, right_beat;
  logic               cap_left, cap_right;
  logic               inc_overrun, inc_sync;
  logic [AUDIO_W-1:0] sample;
  logic               unused_packet_sigs;

  assign unused_packet_sigs = ^{adc_response_startofpacket, adc_response_endofpacket,
                                adc_response_empty};

  assign left_beat  = adc_response_valid && (adc_response_channel == LeftChan);
  assign right_beat = adc_response_valid && (adc_response_channel == RightChan);

  // Both captures take the current beat, so one converter serves left and right.
  adc_sample_convert u_convert (
    .data   (adc_response_data),
    .sample (sample)
  );

  always_comb begin
    state_d     = state_q;
    cap_left    = 1'b0;
    cap_right   = 1'b0;
    inc_overrun = 1'b0;
    inc_sync    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_L;
        WAIT_L: begin
          if (left_beat) begin
            cap_left = 1'b1;
            state_d  = WAIT_R;
          end
        end
        WAIT_R: begin
          if (right_beat) begin
            cap_right = 1'b1;
            state_d   = PRESENT;
          end else if (left_beat) begin
            cap_left = 1'b1;
            inc_sync = 1'b1;
          end
        end
        PRESENT: begin
          // A beat in the handshake cycle is still dropped.
          inc_overrun = left_beat || right_beat;
          if (frame_ready) begin
            state_d = WAIT_L;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      frame_left  <= '0;
      frame_right <= '0;
    end else begin
      state_q <= state_d;
      if (cap_left) begin
        frame_left <= sample;
      end
      if (cap_right) begin
        frame_right <= sample;
      end
    end
  end

  assign frame_valid = (state_q == PRESENT);

`ifdef ADC_SEQ_STATS_EN
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      overrun_count  <= '0;
      sync_err_count <= '0;
    end else begin
      if (inc_overrun && (overrun_count != '1)) begin
        overrun_count <= overrun_count + 1'b1;
      end
      if (inc_sync && (sync_err_count != '1)) begin
        sync_err_count <= sync_err_count + 1'b1;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats   = inc_overrun ^ inc_sync;
  assign overrun_count  = '0;
  assign sync_err_count = '0;
`endif

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Directed bench for adc_frame_sequencer with a frame scoreboard checked at each handshake.
module tb_adc_frame_sequencer;

`ifdef ADC_SEQ_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        adc_valid;
  logic        adc_sop;
  logic        adc_eop;
  logic        adc_empty;
  logic [4:0]  adc_ch;
  logic [11:0] adc_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_left;
  logic [15:0] frame_right;
  logic [7:0]  overrun_count;
  logic [7:0]  sync_err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  adc_frame_sequencer #(
    .LEFT_CH  (1),
    .RIGHT_CH (2)
  ) dut (
    .clk_clk                    (clk),
    .reset_reset                (rst),
    .enable                     (enable),
    .adc_response_valid         (adc_valid),
    .adc_response_startofpacket (adc_sop),
    .adc_response_endofpacket   (adc_eop),
    .adc_response_empty         (adc_empty),
    .adc_response_channel       (adc_ch),
    .adc_response_data          (adc_data),
    .frame_valid                (frame_valid),
    .frame_ready                (frame_ready),
    .frame_left                 (frame_left),
    .frame_right                (frame_right),
    .overrun_count              (overrun_count),
    .sync_err_count             (sync_err_count)
  );

  function automatic logic [15:0] conv(input logic [11:0] d);
    return {~d[11], d[10:0], 4'b0000};
  endfunction

  function automatic logic [7:0] cnt(input int v);
    return Stats ? 8'(v) : 8'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard handshake at negedge, return 1ns after the rising edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (frame_valid && frame_ready) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", {frame_left, frame_right}, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("frame_data", {frame_left, frame_right}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] ch, input logic [11:0] d);
    adc_valid = 1'b1;
    adc_ch    = ch;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
  endtask

  initial begin
    int hs0;
    rst         = 1'b1;
    enable      = 1'b0;
    adc_valid   = 1'b0;
    adc_sop     = 1'b0;
    adc_eop     = 1'b0;
    adc_empty   = 1'b0;
    adc_ch      = 5'd0;
    adc_data    = 12'd0;
    frame_ready = 1'b0;
    #12;
    chk("reset_valid", 32'(frame_valid), 32'd0);
    chk("reset_frame", {frame_left, frame_right}, 32'd0);
    chk("reset_counts", {overrun_count, sync_err_count}, 32'd0);
    rst = 1'b0;
    tick();

    // Stereo frame with immediate accept.
    enable      = 1'b1;
    frame_ready = 1'b1;
    tick();
    beat(5'd1, 12'hFFF);
    chk("left_capture", 32'(frame_left), 32'h7FF0);
    chk("valid_before_right", 32'(frame_valid), 32'd0);
    exp_q.push_back({16'h7FF0, 16'h8000});
    beat(5'd2, 12'h000);
    chk("valid_latency", 32'(frame_valid), 32'd1);
    chk("right_capture", 32'(frame_right), 32'h8000);
    tick();
    chk("valid_drop", 32'(frame_valid), 32'd0);

    // Backpressure with overruns, including a beat in the handshake cycle.
    frame_ready = 1'b0;
    exp_q.push_back({conv(12'h123), conv(12'hABC)});
    beat(5'd1, 12'h123);
    beat(5'd2, 12'hABC);
    beat(5'd1, 12'h555);
    beat(5'd2, 12'h666);
    beat(5'd1, 12'h777);
    chk("held_valid", 32'(frame_valid), 32'd1);
    chk("held_frame", {frame_left, frame_right}, {conv(12'h123), conv(12'hABC)});
    chk("overrun_3", 32'(overrun_count), 32'(cnt(3)));
    frame_ready = 1'b1;
    beat(5'd2, 12'h999);
    chk("after_hs_valid", 32'(frame_valid), 32'd0);
    chk("overrun_hs", 32'(overrun_count), 32'(cnt(4)));

    // Desync: second left overwrites in WAIT_R.
    beat(5'd1, 12'h100);
    beat(5'd1, 12'h800);
    chk("sync_err_1", 32'(sync_err_count), 32'(cnt(1)));
    chk("overwritten_left", 32'(frame_left), 32'h0000);
    exp_q.push_back({16'h0000, 16'h0000});
    beat(5'd2, 12'h800);
    tick();

    // Channel filtering and valid=0 beats.
    hs0 = n_hs;
    exp_q.push_back({conv(12'h200), conv(12'h300)});
    beat(5'd0, 12'hAAA);
    beat(5'd1, 12'h200);
    beat(5'd3, 12'hBBB);
    beat(5'd31, 12'hCCC);
    adc_ch   = 5'd2;
    adc_data = 12'hDDD;
    tick();
    chk("invalid_ignored", 32'(frame_valid), 32'd0);
    beat(5'd2, 12'h300);
    tick();
    tick();
    chk("one_frame", 32'(n_hs - hs0), 32'd1);
    chk("counts_unchanged", {overrun_count, sync_err_count}, {cnt(4), cnt(1)});

    // Disable mid-frame discards the partial pair.
    hs0 = n_hs;
    beat(5'd1, 12'h400);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    beat(5'd2, 12'h500);
    tick();
    tick();
    chk("no_frame_after_disable", {31'd0, frame_valid}, 32'd0);
    chk("no_hs_after_disable", 32'(n_hs - hs0), 32'd0);

    // Asynchronous reset while a frame is presented.
    frame_ready = 1'b0;
    beat(5'd1, 12'h600);
    beat(5'd2, 12'h700);
    chk("present_before_rst", 32'(frame_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(frame_valid), 32'd0);
    chk("async_rst_frame", {frame_left, frame_right}, 32'd0);
    chk("async_rst_counts", {overrun_count, sync_err_count}, 32'd0);
    rst = 1'b0;
    tick();
    tick();

    // Saturation while stalled.
    exp_q.push_back({conv(12'h001), conv(12'h002)});
    beat(5'd1, 12'h001);
    beat(5'd2, 12'h002);
    for (int i = 0; i < 300; i++) begin
      beat((i % 2 == 0) ? 5'd1 : 5'd2, 12'(i));
    end
    chk("overrun_sat", 32'(overrun_count), 32'(cnt(255)));
    chk("sat_frame_held", {frame_left, frame_right}, {conv(12'h001), conv(12'h002)});
    frame_ready = 1'b1;
    tick();
    chk("final_valid", 32'(frame_valid), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
